// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy initiator for the single-port RAM.
// Reads word k from src+k, writes it to dst+k, two cycles per word.
module mem_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic [ADDR_W-1:0] o_count,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_set,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_buf;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic [ADDR_W-1:0] w_next_k;
  logic              w_more;
  logic [ADDR_W-1:0] w_addr;

  // k never exceeds len, so k+1 < len reduces to k+1 != len
  assign w_next_k = r_count + ONE;
  assign w_more   = (w_next_k != r_len);

  // Copy sequencer with registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_count   <= '0;
      r_buf     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src     <= i_src;
            r_dst     <= i_dst;
            r_len     <= i_len;
            r_count   <= '0;
            r_aborted <= 1'b0;
            if (i_len != '0) begin
              r_state <= S_READ;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (i_abort) begin
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_buf   <= i_mem_data;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_count <= w_next_k;
          if (i_abort || !w_more) begin
            r_aborted <= i_abort;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_READ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM address follows the current phase; parked at 0 when idle
  always_comb begin
    w_addr = '0;
    unique case (r_state)
      S_READ:  w_addr = r_src + r_count;
      S_WRITE: w_addr = r_dst + r_count;
      S_IDLE:  w_addr = '0;
      S_DONE:  w_addr = '0;
    endcase
  end

  assign o_mem_addr = w_addr;
  // reset blocks the write even in the middle of a WRITE cycle
  assign o_mem_set  = (r_state == S_WRITE) && !i_rst;
  assign o_mem_data = r_buf;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_aborted  = r_aborted;
  assign o_count    = r_count;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed bench for mem_copy_engine
// with a behavioural RAM model on the engine's port.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_src;
  logic [15:0] i_dst;
  logic [15:0] i_len;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_aborted;
  logic [15:0] o_count;
  logic [15:0] o_mem_addr;
  logic        o_mem_set;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;

  logic [31:0] mem [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [31:0] bd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(16), .DATA_W(32)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_src      (i_src),
    .i_dst      (i_dst),
    .i_len      (i_len),
    .i_abort    (i_abort),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_aborted  (o_aborted),
    .o_count    (o_count),
    .o_mem_addr (o_mem_addr),
    .o_mem_set  (o_mem_set),
    .o_mem_data (o_mem_data),
    .i_mem_data (i_mem_data)
  );

  assign i_mem_data = mem[o_mem_addr];

  // RAM model: engine writes win, backdoor preload otherwise
  always @(posedge clk) begin
    if (o_mem_set)
      mem[o_mem_addr] <= o_mem_data;
    else if (bd_we)
      mem[bd_addr] <= bd_data;
  end

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // returns at the sample point of cycle 1 after the accept edge
  task automatic issue(input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l);
    @(negedge clk);
    i_start = 1'b1;
    i_src   = s;
    i_dst   = d;
    i_len   = l;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({o_busy, o_done, o_aborted, o_mem_set} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {o_busy, o_done, o_aborted, o_mem_set});
    end
    total++;
    if (o_count !== 16'h0 || o_mem_addr !== 16'h0 || o_mem_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs count=%h addr=%h data=%h want 0",
               o_count, o_mem_addr, o_mem_data);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_copy();
    int done_at = -1;
    int ndone = 0;
    logic [31:0] v [4];
    v[0] = 32'hA000_000A; v[1] = 32'hB000_000B;
    v[2] = 32'hC000_000C; v[3] = 32'hD000_000D;
    for (int i = 0; i < 4; i++) begin
      poke(16'(4 + i), v[i]);
      poke(16'(20 + i), 32'h0);
    end
    issue(16'd4, 16'd20, 16'd4);
    for (int c = 1; c <= 12; c++) begin
      if (o_done) begin
        if (done_at < 0) done_at = c;
        ndone++;
      end
      if (c == 9) begin
        total++;
        if (o_aborted !== 1'b0 || o_count !== 16'd4) begin
          bad++;
          $display("FAIL copy_status aborted=%b count=%0d want 0/4",
                   o_aborted, o_count);
        end
      end
      @(negedge clk);
    end
    total++;
    if (done_at != 9 || ndone != 1) begin
      bad++;
      $display("FAIL copy_done_cycle at=%0d n=%0d want 9/1", done_at, ndone);
    end
    total++;
    if (o_count !== 16'd4) begin
      bad++;
      $display("FAIL copy_count_hold got=%0d want 4", o_count);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[20 + i] !== v[i] || mem[4 + i] !== v[i]) begin
        bad++;
        $display("FAIL copy_word%0d dst=%h src=%h want %h",
                 i, mem[20 + i], mem[4 + i], v[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    int done_at = -1;
    bit seen_set = 0;
    issue(16'd3, 16'd9, 16'd0);
    for (int c = 1; c <= 4; c++) begin
      if (o_done && done_at < 0) done_at = c;
      if (o_mem_set) seen_set = 1;
      if (c == 1) begin
        total++;
        if (o_count !== 16'd0 || o_busy !== 1'b0) begin
          bad++;
          $display("FAIL zero_status count=%0d busy=%b want 0/0",
                   o_count, o_busy);
        end
      end
      @(negedge clk);
    end
    total++;
    if (done_at != 1 || seen_set) begin
      bad++;
      $display("FAIL zero_done at=%0d set_seen=%0d want 1/0",
               done_at, seen_set);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [6];
    logic [15:0] got_a [$];
    logic        got_s [$];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'h0010;
    exp_a[2] = 16'hFFFF; exp_a[3] = 16'h0011;
    exp_a[4] = 16'h0000; exp_a[5] = 16'h0012;
    poke(16'hFFFE, 32'h1111_0001);
    poke(16'hFFFF, 32'h2222_0002);
    poke(16'h0000, 32'h3333_0003);
    issue(16'hFFFE, 16'h0010, 16'd3);
    for (int c = 1; c <= 8; c++) begin
      if (o_busy) begin
        got_a.push_back(o_mem_addr);
        got_s.push_back(o_mem_set);
      end
      @(negedge clk);
    end
    total++;
    if (got_a.size() != 6) begin
      bad++;
      $display("FAIL wrap_len got=%0d want 6", got_a.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (got_a[i] !== exp_a[i] || got_s[i] !== 1'(i % 2)) begin
          bad++;
          $display("FAIL wrap_seq%0d addr=%h set=%b want %h/%0d",
                   i, got_a[i], got_s[i], exp_a[i], i % 2);
        end
      end
    end
    total++;
    if (mem[16'h10] !== 32'h1111_0001 || mem[16'h11] !== 32'h2222_0002 ||
        mem[16'h12] !== 32'h3333_0003) begin
      bad++;
      $display("FAIL wrap_data got=%h %h %h want 11110001 22220002 33330003",
               mem[16'h10], mem[16'h11], mem[16'h12]);
    end
  endtask

  task automatic test_abort();
    int done_at = -1;
    for (int i = 0; i < 8; i++) begin
      poke(16'(16'h100 + i), 32'h5000_0000 + 32'(i));
      poke(16'(16'h200 + i), 32'hDEAD_BEEF);
    end
    issue(16'h100, 16'h200, 16'd8);
    for (int c = 1; c <= 10; c++) begin
      if (o_done && done_at < 0) done_at = c;
      if (c == 7) begin
        total++;
        if (o_done !== 1'b1 || o_aborted !== 1'b1 || o_count !== 16'd3) begin
          bad++;
          $display("FAIL abort_status done=%b ab=%b count=%0d want 1/1/3",
                   o_done, o_aborted, o_count);
        end
      end
      i_abort = (c == 6);
      @(negedge clk);
    end
    i_abort = 1'b0;
    total++;
    if (done_at != 7) begin
      bad++;
      $display("FAIL abort_done_cycle got=%0d want 7", done_at);
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = (i < 3) ? 32'h5000_0000 + 32'(i) : 32'hDEAD_BEEF;
      total++;
      if (mem[16'h200 + i] !== e) begin
        bad++;
        $display("FAIL abort_word%0d got=%h want %h", i, mem[16'h200 + i], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      poke(16'(16'h300 + i), 32'h7000_0000 + 32'(i));
      poke(16'(16'h400 + i), 32'hCAFE_F00D);
    end
    issue(16'h300, 16'h400, 16'd4);
    @(negedge clk);
    i_rst = 1'b1;
    #1;
    total++;
    if (o_mem_set !== 1'b0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_set set=%b busy=%b want 0/1", o_mem_set, o_busy);
    end
    @(negedge clk);
    i_rst = 1'b0;
    total++;
    if ({o_busy, o_done, o_aborted, o_mem_set} !== 4'b0000 ||
        o_count !== 16'h0 || o_mem_addr !== 16'h0 ||
        o_mem_data !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_outs flags=%b count=%h addr=%h data=%h want 0",
               {o_busy, o_done, o_aborted, o_mem_set},
               o_count, o_mem_addr, o_mem_data);
    end
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[16'h400 + i] !== 32'hCAFE_F00D) begin
        bad++;
        $display("FAIL rstmid_word%0d got=%h want cafef00d",
                 i, mem[16'h400 + i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_at = -1;
    int ndone = 0;
    for (int i = 0; i < 4; i++)
      poke(16'(16'h500 + i), 32'h9000_0000 + 32'(i));
    poke(16'h0800, 32'h0BAD_0BAD);
    issue(16'h500, 16'h600, 16'd4);
    for (int c = 1; c <= 16; c++) begin
      if (o_done) begin
        if (done_at < 0) done_at = c;
        ndone++;
      end
      if (c == 3) begin
        i_start = 1'b1;
        i_src   = 16'h700;
        i_dst   = 16'h800;
        i_len   = 16'd2;
      end
      if (c == 10) i_start = 1'b0;
      @(negedge clk);
    end
    total++;
    if (done_at != 9 || ndone != 1) begin
      bad++;
      $display("FAIL b2b_done at=%0d n=%0d want 9/1", done_at, ndone);
    end
    total++;
    if (o_count !== 16'd4 || mem[16'h800] !== 32'h0BAD_0BAD ||
        mem[16'h603] !== 32'h9000_0003) begin
      bad++;
      $display("FAIL b2b_result count=%0d m800=%h m603=%h want 4/0bad0bad/90000003",
               o_count, mem[16'h800], mem[16'h603]);
    end
  endtask

  task automatic test_overlap();
    poke(16'd0, 32'h0000_AAAA);
    poke(16'd1, 32'h0000_BBBB);
    poke(16'd2, 32'h0000_CCCC);
    poke(16'd3, 32'h0000_DDDD);
    issue(16'd0, 16'd1, 16'd3);
    repeat (9) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[i] !== 32'h0000_AAAA) begin
        bad++;
        $display("FAIL overlap_word%0d got=%h want 0000aaaa", i, mem[i]);
      end
    end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_src   = '0;
    i_dst   = '0;
    i_len   = '0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    test_reset();
    test_copy();
    test_zero_len();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_overlap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
